ped_crossing_unit: RTL and testbench

//  Pedestrian-side end of the traffic-light interface. Conditions a raw crossing pushbutton into
//  a held request (ped_request -> controller pedestrian_button) and decodes the controller's
//  one-hot lights bus. Drives the WALK/DON'T-WALK lamps, granting WALK only while the road is RED.

---
 rtl/ped_crossing_unit_pkg.sv | 38 +++
 rtl/ped_crossing_unit_debounce.sv | 56 +++++
 rtl/ped_crossing_unit.sv | 162 ++++++++++++++++
 tb/tb_ped_crossing_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ped_crossing_unit_pkg.sv
// Shared definitions for the pedestrian crossing unit: light codes,
// decoded phase codes, FSM states and the lights decoder.
package ped_crossing_unit_pkg;

  // One-hot encodings driven by the traffic-light controller.
  localparam logic [2:0] LIGHTS_RED    = 3'b001;
  localparam logic [2:0] LIGHTS_YELLOW = 3'b010;
  localparam logic [2:0] LIGHTS_GREEN  = 3'b100;

  // Decoded phase as presented on phase_code.
  typedef enum logic [1:0] {
    PHASE_RED     = 2'b00,
    PHASE_YELLOW  = 2'b01,
    PHASE_GREEN   = 2'b10,
    PHASE_INVALID = 2'b11
  } phase_e;

  // Crossing controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQUEST = 2'b01,
    ST_WALK    = 2'b10,
    ST_CLEAR   = 2'b11
  } state_e;

  // Map the one-hot lights bus to a phase; all-zero or multi-hot is invalid.
  function automatic phase_e decode_lights(input logic [2:0] lights);
    phase_e phase;
    case (lights)
      LIGHTS_RED:    phase = PHASE_RED;
      LIGHTS_YELLOW: phase = PHASE_YELLOW;
      LIGHTS_GREEN:  phase = PHASE_GREEN;
      default:       phase = PHASE_INVALID;
    endcase
    return phase;
  endfunction

endpackage

// File: rtl/ped_crossing_unit_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, debounce counter and a
// one-cycle press pulse on each accepted 0->1 change of the debounced level.
module ped_debounce
  import ped_crossing_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  // Count consecutive synchronized samples that disagree with the debounced level.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q >= DB_LAST) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ped_crossing_unit.sv
// Pedestrian-side crossing unit: conditions the pushbutton into a held
// request, decodes the controller lights, drives WALK/DON'T-WALK lamps and
// locks the crossing out on malformed or unsafe light sequences.
module ped_crossing_unit
  import ped_crossing_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_CYCLES     = 8,
  parameter int CLEAR_CYCLES    = 6,
  parameter int FLASH_DIV       = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       button_raw,
  input  logic [2:0] lights,
  input  logic       err_clear,
  output logic       ped_request,
  output logic       walk,
  output logic       walk_flash,
  output logic       dont_walk,
  output logic [1:0] phase_code,
  output logic       lights_error
);

  localparam int CNT_MAX = (WALK_CYCLES > CLEAR_CYCLES) ? WALK_CYCLES : CLEAR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(FLASH_DIV + 1);

  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FLASH_DIV - 1);

  logic press;

  phase_e phase_d, phase_q;
  phase_e prev_phase_d, prev_phase_q;
  logic   err_cond;
  logic   lights_error_d, lights_error_q;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [DIV_W-1:0] div_d, div_q;
  logic             abort;

  logic ped_request_d, ped_request_q;
  logic walk_d, walk_q;
  logic walk_flash_d, walk_flash_q;
  logic dont_walk_d, dont_walk_q;

  ped_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_i  (button_raw),
    .press_o(press)
  );

  // Decode lights and evaluate the sticky error flag; a live error beats err_clear.
  always_comb begin
    phase_d = decode_lights(lights);
    // prev phase remembers the last valid phase so GREEN -> glitch -> RED is still caught.
    prev_phase_d = (phase_d != PHASE_INVALID) ? phase_d : prev_phase_q;
    err_cond = (phase_d == PHASE_INVALID) ||
               ((prev_phase_q == PHASE_GREEN) && (phase_d == PHASE_RED));
    if (err_cond) begin
      lights_error_d = 1'b1;
    end else if (err_clear) begin
      lights_error_d = 1'b0;
    end else begin
      lights_error_d = lights_error_q;
    end
  end

  // Crossing FSM next state, phase counters and registered lamp outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    div_d        = '0;
    walk_flash_d = 1'b0;
    abort        = lights_error_q || err_cond;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press) state_d = ST_REQUEST;
        end
        ST_REQUEST: begin
          if (phase_d == PHASE_RED) state_d = ST_WALK;
        end
        ST_WALK: begin
          if (phase_d != PHASE_RED)   state_d = ST_IDLE;
          else if (cnt_q >= WALK_LAST) state_d = ST_CLEAR;
        end
        ST_CLEAR: begin
          if (phase_d != PHASE_RED)    state_d = ST_IDLE;
          else if (cnt_q >= CLEAR_LAST) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Dwell counter restarts on every state change and saturates otherwise.
    if ((state_d == state_q) && ((state_q == ST_WALK) || (state_q == ST_CLEAR))) begin
      cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Flash starts lit on entry to CLEAR and toggles every FLASH_DIV cycles.
    if (state_d == ST_CLEAR) begin
      if (state_q != ST_CLEAR) begin
        walk_flash_d = 1'b1;
      end else if (div_q >= DIV_LAST) begin
        walk_flash_d = ~walk_flash_q;
      end else begin
        div_d        = div_q + DIV_W'(1);
        walk_flash_d = walk_flash_q;
      end
    end

    ped_request_d = (state_d == ST_REQUEST);
    walk_d        = (state_d == ST_WALK);
    dont_walk_d   = (state_d == ST_IDLE) || (state_d == ST_REQUEST);
  end

  // State, decode and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      div_q          <= '0;
      phase_q        <= PHASE_RED;
      prev_phase_q   <= PHASE_RED;
      lights_error_q <= 1'b0;
      ped_request_q  <= 1'b0;
      walk_q         <= 1'b0;
      walk_flash_q   <= 1'b0;
      dont_walk_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      phase_q        <= phase_d;
      prev_phase_q   <= prev_phase_d;
      lights_error_q <= lights_error_d;
      ped_request_q  <= ped_request_d;
      walk_q         <= walk_d;
      walk_flash_q   <= walk_flash_d;
      dont_walk_q    <= dont_walk_d;
    end
  end

  assign ped_request  = ped_request_q;
  assign walk         = walk_q;
  assign walk_flash   = walk_flash_q;
  assign dont_walk    = dont_walk_q;
  assign phase_code   = phase_q;
  assign lights_error = lights_error_q;

endmodule

// File: tb/tb_ped_crossing_unit.sv
// Directed bench for ped_crossing_unit: expectations are queued as stimulus
// is applied and compared against sampled outputs #1 after the clock edge.
module tb_ped_crossing_unit;

  localparam int DEBOUNCE_N = 4;
  localparam int WALK_N     = 8;
  localparam int CLEAR_N    = 6;
  localparam int FLASH_N    = 2;
  localparam int PRESS_LAT  = DEBOUNCE_N + 3;

  logic       clk;
  logic       reset_n;
  logic       button_raw;
  logic [2:0] lights;
  logic       err_clear;
  logic       ped_request;
  logic       walk;
  logic       walk_flash;
  logic       dont_walk;
  logic [1:0] phase_code;
  logic       lights_error;

  typedef enum {S_REQ, S_WALK, S_FLASH, S_DW, S_PHASE, S_ERR} sig_e;
  typedef struct {
    string      tag;
    sig_e       sig;
    logic [1:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   seen;

  ped_crossing_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .button_raw  (button_raw),
    .lights      (lights),
    .err_clear   (err_clear),
    .ped_request (ped_request),
    .walk        (walk),
    .walk_flash  (walk_flash),
    .dont_walk   (dont_walk),
    .phase_code  (phase_code),
    .lights_error(lights_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] observe(input sig_e s);
    case (s)
      S_REQ:   return {1'b0, ped_request};
      S_WALK:  return {1'b0, walk};
      S_FLASH: return {1'b0, walk_flash};
      S_DW:    return {1'b0, dont_walk};
      S_PHASE: return phase_code;
      default: return {1'b0, lights_error};
    endcase
  endfunction

  task automatic exp_push(input string tag, input sig_e s, input logic [1:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [1:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sig);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%b expected=%b", e.tag, o, e.val);
      end
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until the selected output reaches val or the budget runs out.
  task automatic wait_for(input sig_e s, input logic [1:0] v, input int budget, output int cnt);
    cnt = 0;
    while ((observe(s) !== v) && (cnt < budget)) begin
      cyc(1);
      cnt++;
    end
  endtask

  task automatic push_idle_lamps(input string tag);
    exp_push(tag, S_WALK,  2'b00);
    exp_push(tag, S_FLASH, 2'b00);
    exp_push(tag, S_DW,    2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    button_raw = 1'b0;
    lights     = 3'b001;
    err_clear  = 1'b0;
    cyc(2);

    // Reset values.
    exp_push("rst_req", S_REQ, 2'b00);
    push_idle_lamps("rst_lamps");
    exp_push("rst_phase", S_PHASE, 2'b00);
    exp_push("rst_err", S_ERR, 2'b00);
    drain();
    reset_n = 1'b1;
    cyc(2);

    // Short chatter on GREEN: no request.
    lights = 3'b100;
    cyc(2);
    button_raw = 1'b1;
    cyc(2);
    button_raw = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (ped_request === 1'b1) seen = 1;
    end
    check_int("short_pulse_no_req", seen, 0);
    exp_push("short_pulse_phase", S_PHASE, 2'b10);
    exp_push("short_pulse_err", S_ERR, 2'b00);
    drain();

    // Held press on GREEN: request after debounce, held through YELLOW.
    button_raw = 1'b1;
    wait_for(S_REQ, 2'b01, 20, n);
    check_int("press_latency", n, PRESS_LAT);
    exp_push("req_raised", S_REQ, 2'b01);
    exp_push("req_dont_walk", S_DW, 2'b01);
    drain();
    cyc(10 - PRESS_LAT);
    button_raw = 1'b0;
    cyc(2);
    exp_push("req_held_green", S_REQ, 2'b01);
    drain();
    lights = 3'b010;
    cyc(3);
    exp_push("req_held_yellow", S_REQ, 2'b01);
    exp_push("yellow_phase", S_PHASE, 2'b01);
    exp_push("yellow_no_err", S_ERR, 2'b00);
    drain();

    // RED arrives: grant next edge, full walk and clearance.
    lights = 3'b001;
    cyc(1);
    for (int i = 0; i < WALK_N; i++) begin
      exp_push("walk_on", S_WALK, 2'b01);
      exp_push("walk_dw_off", S_DW, 2'b00);
      exp_push("walk_req_off", S_REQ, 2'b00);
      drain();
      cyc(1);
    end
    for (int i = 0; i < CLEAR_N; i++) begin
      exp_push("clear_walk_off", S_WALK, 2'b00);
      exp_push("clear_dw_off", S_DW, 2'b00);
      exp_push("clear_flash", S_FLASH, (((i / FLASH_N) % 2) == 0) ? 2'b01 : 2'b00);
      drain();
      cyc(1);
    end
    push_idle_lamps("after_clear");
    exp_push("after_clear_err", S_ERR, 2'b00);
    drain();

    // Immediate grant with RED steady, then abort by GREEN during WALK.
    cyc(4);
    button_raw = 1'b1;
    wait_for(S_REQ, 2'b01, 20, n);
    check_int("imm_press_latency", n, PRESS_LAT);
    exp_push("imm_req", S_REQ, 2'b01);
    exp_push("imm_no_walk_yet", S_WALK, 2'b00);
    drain();
    cyc(1);
    exp_push("imm_req_one_cycle", S_REQ, 2'b00);
    exp_push("imm_walk", S_WALK, 2'b01);
    drain();
    button_raw = 1'b0;
    cyc(2);
    lights = 3'b100;
    cyc(1);
    push_idle_lamps("abort_green");
    exp_push("abort_no_err", S_ERR, 2'b00);
    exp_push("abort_phase", S_PHASE, 2'b10);
    drain();

    // Invalid encoding: error set, presses discarded.
    cyc(2);
    lights = 3'b011;
    cyc(1);
    exp_push("invalid_phase", S_PHASE, 2'b11);
    exp_push("invalid_err", S_ERR, 2'b01);
    drain();
    lights = 3'b010;
    button_raw = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(1);
      if (ped_request === 1'b1) seen = 1;
    end
    button_raw = 1'b0;
    check_int("err_press_ignored", seen, 0);
    exp_push("err_sticky", S_ERR, 2'b01);
    exp_push("err_dont_walk", S_DW, 2'b01);
    drain();
    cyc(8);

    // err_clear with RED steady clears the flag; presses accepted again.
    lights = 3'b001;
    cyc(1);
    exp_push("err_before_clear", S_ERR, 2'b01);
    drain();
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    exp_push("err_cleared", S_ERR, 2'b00);
    drain();
    button_raw = 1'b1;
    wait_for(S_REQ, 2'b01, 20, n);
    exp_push("post_clear_req", S_REQ, 2'b01);
    drain();
    cyc(1);
    exp_push("post_clear_walk", S_WALK, 2'b01);
    drain();
    button_raw = 1'b0;
    cyc(2);
    lights = 3'b100;
    cyc(1);
    exp_push("abort2_walk_off", S_WALK, 2'b00);
    exp_push("abort2_no_err", S_ERR, 2'b00);
    drain();

    // GREEN -> RED skipping YELLOW.
    lights = 3'b001;
    cyc(1);
    exp_push("skip_yellow_err", S_ERR, 2'b01);
    exp_push("skip_yellow_phase", S_PHASE, 2'b00);
    exp_push("skip_yellow_dw", S_DW, 2'b01);
    drain();

    // Error condition in the same cycle as err_clear wins.
    lights = 3'b011;
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    exp_push("clear_vs_error", S_ERR, 2'b01);
    drain();
    lights = 3'b001;
    cyc(1);
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    exp_push("clear_after_red", S_ERR, 2'b00);
    drain();

    // Asynchronous reset in the middle of CLEAR.
    cyc(8);
    button_raw = 1'b1;
    wait_for(S_WALK, 2'b01, 20, n);
    button_raw = 1'b0;
    exp_push("pre_rst_walk", S_WALK, 2'b01);
    drain();
    cyc(WALK_N + 1);
    exp_push("mid_clear_walk", S_WALK, 2'b00);
    exp_push("mid_clear_dw", S_DW, 2'b00);
    exp_push("mid_clear_flash", S_FLASH, 2'b01);
    drain();
    #2;
    reset_n = 1'b0;
    #1;
    exp_push("async_rst_req", S_REQ, 2'b00);
    push_idle_lamps("async_rst_lamps");
    exp_push("async_rst_phase", S_PHASE, 2'b00);
    exp_push("async_rst_err", S_ERR, 2'b00);
    drain();
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
